mem_port_arbiter: RTL

- Arbitrates one single-port memory between the instruction-fetch (IF) port and the load/store (D) port of the core.
- Every cycle, grants at most one requester and drives the memory port.
- Returns read data to the granted requester one cycle later, tagged with the owning port.
- Sits between the pipeline's IF/MEM stages and the shared instruction/data memory. Data has priority; a starvation counter guarantees IF progress.

---
 rtl/mem_port_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the instruction-fetch (IF) and load/store (D) requesters.
// Latency: grant and memory drive are combinational; read data returns one cycle after the grant, tagged by owner.
// Backpressure: D normally wins; IF is forced through after STARVE_LIMIT consecutive denied cycles.
module mem_port_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,

    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,

    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       rvalid_q;
    owner_e     rd_owner_q;
    logic       starved;
    logic       if_win;
    logic       d_win;

    // Pick at most one winner; nothing is granted while reset is held low.
    always_comb begin
        starved = (starve_cnt == LIMIT);
        if_win  = rst_i & if_req_i & (~d_req_i | starved);
        d_win   = rst_i & d_req_i & ~if_win;
    end

    assign if_gnt_o = if_win;
    assign d_gnt_o  = d_win;

    // Steer the winner's request onto the memory port; idle port drives zeros.
    always_comb begin
        mem_en_o    = if_win | d_win;
        mem_we_o    = d_win & d_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (d_win) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (if_win) begin
            mem_addr_o = if_addr_i;
        end
    end

    // Count consecutive cycles IF asked but lost, saturating at the limit.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            starve_cnt <= '0;
        end else if (if_req_i & ~if_win) begin
            starve_cnt <= starved ? starve_cnt : starve_cnt + 4'd1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Remember that a read was issued and who owns the data arriving next cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rvalid_q   <= 1'b0;
            rd_owner_q <= OWNER_IF;
        end else begin
            rvalid_q   <= mem_en_o & ~mem_we_o;
            rd_owner_q <= d_win ? OWNER_D : OWNER_IF;
        end
    end

    // Route returning read data to its owner; the other side sees zeros.
    // Gating with reset keeps a read issued just before reset from surfacing.
    always_comb begin
        if_rvalid_o = rst_i & rvalid_q & (rd_owner_q == OWNER_IF);
        d_rvalid_o  = rst_i & rvalid_q & (rd_owner_q == OWNER_D);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o  ? mem_rdata_i : '0;
    end

endmodule
